// File: rtl/adma_desc_fetch.sv
// ADMA descriptor fetcher: walks a descriptor table in RAM and hands
// transfer descriptors to the transfer engine, with link/end/int handling.
module adma_desc_fetch #(
  parameter int MAX_DESC = 1024
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        adma_start,
  input  logic [63:0] desc_base,
  input  logic        dir_in,
  input  logic        stop,
  output logic        ram_read,
  output logic [63:0] ram_address,
  input  logic [31:0] data_from_ram,
  output logic        start,
  output logic        direction,
  output logic [63:0] address_init,
  output logic [15:0] length,
  input  logic        TFC,
  output logic        int_req,
  output logic        adma_done,
  output logic        adma_error,
  output logic [1:0]  err_state,
  output logic [63:0] err_addr
);

  localparam int CW = $clog2(MAX_DESC + 1);

  localparam logic [1:0] ERR_FDS  = 2'b01;
  localparam logic [1:0] ERR_CADR = 2'b10;

  localparam logic [1:0] ACT_TRAN = 2'b10;
  localparam logic [1:0] ACT_LINK = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_FETCH2,
    S_LATCH,
    S_DECODE,
    S_TRAN_START,
    S_TRAN_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q;
  logic [63:0]   ptr_q;
  logic [CW-1:0] count_q;
  logic          busy_seen_q;
  logic [15:0]   len_q;
  logic [1:0]    act_q;
  logic          int_q;
  logic          end_q;
  logic          valid_q;
  logic [31:0]   word1_q;
  logic [31:0]   word2_q;

  logic [63:0]   desc_addr_d;
  logic [63:0]   ptr_step_d;

  assign desc_addr_d = {word2_q, word1_q};
  assign ptr_step_d  = ptr_q + 64'd12;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      ptr_q        <= 64'h0;
      count_q      <= '0;
      busy_seen_q  <= 1'b0;
      len_q        <= 16'h0;
      act_q        <= 2'b00;
      int_q        <= 1'b0;
      end_q        <= 1'b0;
      valid_q      <= 1'b0;
      word1_q      <= 32'h0;
      word2_q      <= 32'h0;
      ram_read     <= 1'b0;
      ram_address  <= 64'h0;
      start        <= 1'b0;
      direction    <= 1'b0;
      address_init <= 64'h0;
      length       <= 16'h0;
      int_req      <= 1'b0;
      adma_done    <= 1'b0;
      adma_error   <= 1'b0;
      err_state    <= 2'b00;
      err_addr     <= 64'h0;
    end else begin
      // Pulse outputs and the read strobe are re-asserted only by the
      // transition that needs them.
      start     <= 1'b0;
      int_req   <= 1'b0;
      adma_done <= 1'b0;
      ram_read  <= 1'b0;

      if (stop && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (adma_start) begin
              ptr_q       <= desc_base;
              direction   <= dir_in;
              count_q     <= '0;
              adma_error  <= 1'b0;
              ram_read    <= 1'b1;
              ram_address <= desc_base;
              state_q     <= S_FETCH0;
            end
          end
          S_FETCH0: begin
            ram_read    <= 1'b1;
            ram_address <= ptr_q + 64'd4;
            state_q     <= S_FETCH1;
          end
          S_FETCH1: begin
            len_q       <= data_from_ram[31:16];
            act_q       <= data_from_ram[5:4];
            int_q       <= data_from_ram[2];
            end_q       <= data_from_ram[1];
            valid_q     <= data_from_ram[0];
            ram_read    <= 1'b1;
            ram_address <= ptr_q + 64'd8;
            state_q     <= S_FETCH2;
          end
          S_FETCH2: begin
            word1_q <= data_from_ram;
            state_q <= S_LATCH;
          end
          S_LATCH: begin
            word2_q <= data_from_ram;
            state_q <= S_DECODE;
          end
          S_DECODE: begin
            if ((count_q == CW'(MAX_DESC)) || !valid_q) begin
              adma_error <= 1'b1;
              err_state  <= ERR_FDS;
              err_addr   <= ptr_q;
              state_q    <= S_ERROR;
            end else begin
              count_q <= count_q + 1'b1;
              if (act_q == ACT_TRAN) begin
                if ((len_q == 16'h0) || (desc_addr_d[1:0] != 2'b00)) begin
                  adma_error <= 1'b1;
                  err_state  <= ERR_CADR;
                  err_addr   <= ptr_q;
                  state_q    <= S_ERROR;
                end else begin
                  address_init <= desc_addr_d;
                  length       <= len_q;
                  start        <= 1'b1;
                  state_q      <= S_TRAN_START;
                end
              end else if (act_q == ACT_LINK) begin
                if (desc_addr_d[1:0] != 2'b00) begin
                  adma_error <= 1'b1;
                  err_state  <= ERR_CADR;
                  err_addr   <= ptr_q;
                  state_q    <= S_ERROR;
                end else begin
                  int_req     <= int_q;
                  ptr_q       <= desc_addr_d;
                  ram_read    <= 1'b1;
                  ram_address <= desc_addr_d;
                  state_q     <= S_FETCH0;
                end
              end else if (end_q) begin
                adma_done <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                ptr_q       <= ptr_step_d;
                ram_read    <= 1'b1;
                ram_address <= ptr_step_d;
                state_q     <= S_FETCH0;
              end
            end
          end
          S_TRAN_START: begin
            busy_seen_q <= 1'b0;
            state_q     <= S_TRAN_WAIT;
          end
          S_TRAN_WAIT: begin
            // A TFC high left over from the previous transfer must not end this one.
            if (TFC && busy_seen_q) begin
              int_req <= int_q;
              if (end_q) begin
                adma_done <= 1'b1;
                state_q   <= S_DONE;
              end else begin
                ptr_q       <= ptr_step_d;
                ram_read    <= 1'b1;
                ram_address <= ptr_step_d;
                state_q     <= S_FETCH0;
              end
            end else if (!TFC) begin
              busy_seen_q <= 1'b1;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          S_ERROR: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
